pipes_sumsquare: RTL and testbench



---
 rtl/pipes_pkg.sv | 20 ++
 rtl/pipes_sumsquare_lane.sv | 69 ++++++
 rtl/pipes_sumsquare.sv | 39 +++
 tb/tb_pipes_sumsquare.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/pipes_pkg.sv
// Shared constants, lane word type and binary32 packing helper for the sum-of-squares pipeline.
package pipes_pkg;

    localparam int LANES    = 16;
    localparam int WIDTH    = 32;
    localparam int FLT_BIAS = 127;
    localparam int MANT_W   = 23;
    localparam int EXP_W    = 8;

    typedef logic [WIDTH-1:0] lane_word_t;

    function automatic lane_word_t float_pack(
        input logic             sign,
        input logic [EXP_W-1:0] exp,
        input logic [MANT_W-1:0] mant
    );
        return {sign, exp, mant};
    endfunction

endpackage

// File: rtl/pipes_sumsquare_lane.sv
// One lane: (a+b)^2 as binary32, three registered stages advanced by EN.
// PIPES_SUMSQUARE_TRUNC_EN selects round-toward-zero instead of round-to-nearest-even.
module sumsquare_lane
    import pipes_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN,
    input  lane_word_t a,
    input  lane_word_t b,
    output lane_word_t result
);

    logic [32:0]        sum;
    logic [32:0]        abs_d;
    logic [32:0]        abs_q;
    logic [65:0]        prod_q;
    logic [6:0]         lead;
    logic [64:0]        norm;
    logic [MANT_W-1:0]  mant;
    logic               rnd;
    logic [MANT_W:0]    mant_r;
    logic [EXP_W-1:0]   exp_v;
    lane_word_t         res_d;
`ifndef PIPES_SUMSQUARE_TRUNC_EN
    logic               guard;
    logic               sticky;
`endif

    // 33-bit sum cannot overflow; magnitude of -2^32 is 2^32 when read unsigned.
    always_comb begin
        sum   = {a[WIDTH-1], a} + {b[WIDTH-1], b};
        abs_d = sum[32] ? (~sum + 33'd1) : sum;
    end

    always_comb begin
        lead = '0;
        for (int i = 0; i < 66; i++) begin
            if (prod_q[i]) lead = 7'(i);
        end
        // Leading one lands on bit 65 and is dropped; mantissa/guard/sticky follow below it.
        norm = 65'(prod_q << (7'd65 - lead));
        mant = norm[64:42];
`ifdef PIPES_SUMSQUARE_TRUNC_EN
        rnd = 1'b0;
`else
        guard  = norm[41];
        sticky = |norm[40:0];
        rnd    = guard & (sticky | mant[0]);
`endif
        mant_r = {1'b0, mant} + (MANT_W+1)'(rnd);
        // On a rounding carry mant_r[22:0] is already zero.
        exp_v  = EXP_W'(FLT_BIAS) + EXP_W'(lead) + EXP_W'(mant_r[MANT_W]);
        res_d  = (prod_q == '0) ? '0 : float_pack(1'b0, exp_v, mant_r[MANT_W-1:0]);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            abs_q  <= '0;
            prod_q <= '0;
            result <= '0;
        end else if (EN) begin
            abs_q  <= abs_d;
            prod_q <= 66'(abs_q) * 66'(abs_q);
            result <= res_d;
        end
    end

endmodule

// File: rtl/pipes_sumsquare.sv
// 16-lane (a+b)^2 to binary32, 3 enabled edges of latency; EN=0 freezes all stages and VALID.
// Build option PIPES_SUMSQUARE_TRUNC_EN switches every lane to truncating float conversion.
module pipes_sumsquare
    import pipes_pkg::*;
(
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   EN,
    input  logic [LANES*WIDTH-1:0] vals0,
    input  logic [LANES*WIDTH-1:0] vals1,
    output logic [LANES*WIDTH-1:0] pipeout,
    output logic                   VALID
);

    logic [2:0] valid_sr;

    // Lane 0 occupies the most significant word of each bus.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sumsquare_lane u_lane (
            .CLK    (CLK),
            .RST    (RST),
            .EN     (EN),
            .a      (vals0[(LANES-1-g)*WIDTH +: WIDTH]),
            .b      (vals1[(LANES-1-g)*WIDTH +: WIDTH]),
            .result (pipeout[(LANES-1-g)*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_sr <= '0;
        end else if (EN) begin
            valid_sr <= {valid_sr[1:0], 1'b1};
        end
    end

    assign VALID = valid_sr[2];

endmodule

// File: tb/tb_pipes_sumsquare.sv
// Directed checks of pipes_sumsquare: per-lane arithmetic, rounding, extremes, enable hold, async reset.
module tb_pipes_sumsquare;

    logic         CLK;
    logic         RST;
    logic         EN;
    logic [511:0] vals0;
    logic [511:0] vals1;
    logic [511:0] pipeout;
    logic         VALID;

    int n_vec = 0;
    int n_bad = 0;

    pipes_sumsquare dut (
        .CLK     (CLK),
        .RST     (RST),
        .EN      (EN),
        .vals0   (vals0),
        .vals1   (vals1),
        .pipeout (pipeout),
        .VALID   (VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [31:0] a_tab [16] = '{
        32'h00000011, 32'hFFFFFFEF, 32'h00000011, 32'hFFFFFFEF,
        32'h00007530, 32'hFFFF8AD0, 32'h0000028A, 32'hFFFFFD76,
        32'h000002AA, 32'hFFFFFD56, 32'h80000000, 32'h7FFFFFFF,
        32'h00000000, 32'h00001000, 32'hFFFFFFFF, 32'h7FFFFFFF
    };
    logic [31:0] b_tab [16] = '{
        32'h0000000C, 32'h0000000C, 32'hFFFFFFF4, 32'hFFFFFFF4,
        32'h000000C8, 32'h000000C8, 32'h00000279, 32'h00000279,
        32'h0001863C, 32'h0001863C, 32'h80000000, 32'h7FFFFFFF,
        32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000
    };
    // Lane 7: -650+633 = -17, 289 = 0x121 -> 0x43908000. Lane 13: 4097^2 is an exact tie, stays even.
`ifdef PIPES_SUMSQUARE_TRUNC_EN
    logic [31:0] exp_a [16] = '{
        32'h44524000, 32'h41C80000, 32'h41C80000, 32'h44524000,
        32'h4E597281, 32'h4E53B9A9, 32'h49C8F048, 32'h43908000,
        32'h5016C04B, 32'h5012B0AF, 32'h5F800000, 32'h5F7FFFFF,
        32'h00000000, 32'h4B801000, 32'h40800000, 32'h3F800000
    };
`else
    logic [31:0] exp_a [16] = '{
        32'h44524000, 32'h41C80000, 32'h41C80000, 32'h44524000,
        32'h4E597281, 32'h4E53B9A9, 32'h49C8F048, 32'h43908000,
        32'h5016C04C, 32'h5012B0B0, 32'h5F800000, 32'h5F800000,
        32'h00000000, 32'h4B801000, 32'h40800000, 32'h3F800000
    };
`endif
    // Vector B: lane i gets a=i, b=-2i, so the result is i^2.
    logic [31:0] exp_b [16] = '{
        32'h00000000, 32'h3F800000, 32'h40800000, 32'h41100000,
        32'h41800000, 32'h41C80000, 32'h42100000, 32'h42440000,
        32'h42800000, 32'h42A20000, 32'h42C80000, 32'h42F20000,
        32'h43100000, 32'h43290000, 32'h43440000, 32'h43610000
    };
    logic [31:0] exp_zero [16] = '{default: 32'h0};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] lane_of(input logic [511:0] bus, input int i);
        return bus[(15-i)*32 +: 32];
    endfunction

    task automatic check_bus(input string tag, input logic [31:0] want [16]);
        for (int i = 0; i < 16; i++)
            check($sformatf("%s_lane%0d", tag, i), lane_of(pipeout, i), want[i]);
    endtask

    task automatic load_a();
        for (int i = 0; i < 16; i++) begin
            vals0[(15-i)*32 +: 32] = a_tab[i];
            vals1[(15-i)*32 +: 32] = b_tab[i];
        end
    endtask

    task automatic load_b();
        for (int i = 0; i < 16; i++) begin
            vals0[(15-i)*32 +: 32] = 32'(i);
            vals1[(15-i)*32 +: 32] = 32'(-2 * i);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST   = 1'b1;
        EN    = 1'b0;
        vals0 = '0;
        vals1 = '0;
        #12;
        check("reset_valid", 32'(VALID), 32'd0);
        check_bus("reset_out", exp_zero);

        @(negedge CLK);
        RST = 1'b0;
        EN  = 1'b1;
        load_a();
        step();
        check("valid_edge1", 32'(VALID), 32'd0);
        load_b();
        step();
        check("valid_edge2", 32'(VALID), 32'd0);
        vals0 = '0;
        vals1 = '0;
        step();
        check("valid_edge3", 32'(VALID), 32'd1);
        check_bus("vec_a", exp_a);

        // Hold: A stays on the output while B sits one stage behind.
        EN = 1'b0;
        repeat (4) step();
        check("hold_valid", 32'(VALID), 32'd1);
        check_bus("hold_a", exp_a);

        EN = 1'b1;
        step();
        check_bus("vec_b", exp_b);
        step();
        check_bus("vec_zero", exp_zero);

        // Async reset between edges, with data in flight.
        load_a();
        step();
        step();
        #2;
        RST = 1'b1;
        #1;
        check("async_rst_valid", 32'(VALID), 32'd0);
        check_bus("async_rst_out", exp_zero);
        @(negedge CLK);
        RST = 1'b0;
        step();
        step();
        check("refill_valid2", 32'(VALID), 32'd0);
        check("refill_lane0_2", lane_of(pipeout, 0), 32'h0);
        step();
        check("refill_valid3", 32'(VALID), 32'd1);
        check_bus("refill_a", exp_a);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
